gb_vga_scanout: RTL and testbench



---
 rtl/gb_vga_pkg.sv | 44 ++++
 rtl/gb_vga_timing.sv | 61 ++++++
 rtl/gb_vga_scanout.sv | 197 +++++++++++++++++++
 tb/tb_gb_vga_scanout.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_vga_pkg
// Purpose  : Shared constants and types for the Game Boy VGA scanout path:
//            640x480@60 timing, Game Boy image geometry, framebuffer depth,
//            shade and 4:4:4 RGB types.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package gb_vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

    // Source image geometry
    localparam int GB_WIDTH  = 160;
    localparam int GB_HEIGHT = 144;
    localparam int SCALE     = 3;
    localparam int FB_DEPTH  = GB_WIDTH * GB_HEIGHT;               // 23040

    // Width of the h/v position counters (covers 0..799)
    localparam int CNT_W     = 10;

    typedef logic [1:0] shade_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage : gb_vga_pkg
`default_nettype wire

// File: rtl/gb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : gb_vga_timing
// Purpose  : 640x480@60 raster counters. Produces the current position and
//            the position-derived strobes (syncs, visible, frame start),
//            all combinational from the registered counters.
// Ports    : clk            pixel clock
//            rst            synchronous active-high reset
//            o_h, o_v       current column / line
//            o_hsync_n      horizontal sync, active-low
//            o_vsync_n      vertical sync, active-low
//            o_visible      position lies in the 640x480 active area
//            o_frame_start  position is (0,0)
// Revision : 1.0  initial release
// ============================================================================
module gb_vga_timing
    import gb_vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_visible,
    output logic             o_frame_start
);

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_h_vis      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] c_v_vis      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_hsync_n     = !((r_h >= c_hs_start) && (r_h < c_hs_end));
    assign o_vsync_n     = !((r_v >= c_vs_start) && (r_v < c_vs_end));
    assign o_visible     = (r_h < c_h_vis) && (r_v < c_v_vis);
    assign o_frame_start = (r_h == '0) && (r_v == '0);

endmodule : gb_vga_timing
`default_nettype wire

// File: rtl/gb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : gb_vga_scanout
// Purpose  : Framebuffer read side for a 160x144 Game Boy image shown 3x
//            scaled and centred in 640x480@60 VGA. Generates read addresses
//            incrementally, maps shades to RGB and delays the syncs so that
//            everything at the pins lags the raster counters by 2 clocks.
// Config   : DMG_PALETTE_EN  defined   -> classic green DMG palette
//                            undefined -> grey palette
// Ports    : VGA_CLK      pixel clock (25.175 MHz)
//            RST          synchronous active-high reset
//            FB_RADDR     framebuffer read address (registered)
//            FB_DOUT      framebuffer read data for the current FB_RADDR
//            VGA_HSYNC    horizontal sync, active-low
//            VGA_VSYNC    vertical sync, active-low
//            VGA_R/G/B    4-bit colour channels
//            FRAME_START  one-cycle pulse with pixel (0,0) at the pins
// Revision : 1.0  initial release
// ============================================================================
module gb_vga_scanout
    import gb_vga_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 2,
    parameter int H_OFFSET   = 80,
    parameter int V_OFFSET   = 24
)(
    input  logic                  VGA_CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] FB_RADDR,
    input  logic [DATA_WIDTH-1:0] FB_DOUT,
    output logic                  VGA_HSYNC,
    output logic                  VGA_VSYNC,
    output logic [3:0]            VGA_R,
    output logic [3:0]            VGA_G,
    output logic [3:0]            VGA_B,
    output logic                  FRAME_START
);

    localparam logic [CNT_W-1:0]      c_win_x0   = CNT_W'(H_OFFSET);
    localparam logic [CNT_W-1:0]      c_win_x1   = CNT_W'(H_OFFSET + GB_WIDTH * SCALE - 1);
    localparam logic [CNT_W-1:0]      c_win_y0   = CNT_W'(V_OFFSET);
    localparam logic [CNT_W-1:0]      c_win_y1   = CNT_W'(V_OFFSET + GB_HEIGHT * SCALE - 1);
    localparam logic [1:0]            c_sub_last = 2'(SCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_row_step = ADDR_WIDTH'(GB_WIDTH);

    // ---------------------------------------------------------------- timing
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_visible;
    logic             w_frame_start;

    gb_vga_timing u_timing (
        .clk           (VGA_CLK),
        .rst           (RST),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n),
        .o_visible     (w_visible),
        .o_frame_start (w_frame_start)
    );

    logic w_win_row;
    logic w_in_win;
    logic w_line_end;

    assign w_win_row  = (w_v >= c_win_y0) && (w_v <= c_win_y1);
    assign w_in_win   = w_visible && w_win_row && (w_h >= c_win_x0) && (w_h <= c_win_x1);
    assign w_line_end = w_win_row && (w_h == c_win_x1);

    // ------------------------------------------------ address generation (stage 1)
    // r_xsub/r_xidx describe the pixel currently at the counters. They are
    // held at zero outside the window, so they are already correct on the
    // first window column. r_xidx briefly reaches 160 after the last column;
    // that value is never used because the next column is outside the window.
    logic [1:0]            r_xsub;
    logic [7:0]            r_xidx;
    logic [1:0]            r_ysub;
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic [ADDR_WIDTH-1:0] r_raddr;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_xsub      <= '0;
            r_xidx      <= '0;
            r_ysub      <= '0;
            r_line_base <= '0;
            r_raddr     <= '0;
        end else begin
            if (w_in_win) begin
                r_raddr <= r_line_base + ADDR_WIDTH'(r_xidx);
                if (r_xsub == c_sub_last) begin
                    r_xsub <= '0;
                    r_xidx <= r_xidx + 8'd1;
                end else begin
                    r_xsub <= r_xsub + 2'd1;
                end
            end else begin
                r_xsub <= '0;
                r_xidx <= '0;
            end

            // Line base steps one source row after its third repeat, and
            // restarts on every line 0 so a frame never inherits stale state.
            if (w_v == '0) begin
                r_ysub      <= '0;
                r_line_base <= '0;
            end else if (w_line_end) begin
                if (r_ysub == c_sub_last) begin
                    r_ysub      <= '0;
                    r_line_base <= r_line_base + c_row_step;
                end else begin
                    r_ysub <= r_ysub + 2'd1;
                end
            end
        end
    end

    assign FB_RADDR = r_raddr;

    // ------------------------------------------------------------- palette
    rgb444_t w_pal;

    always_comb begin
        w_pal = '0;
        case (shade_t'(FB_DOUT))
`ifdef DMG_PALETTE_EN
            2'd0:    w_pal = {4'h9, 4'hB, 4'h1};
            2'd1:    w_pal = {4'h8, 4'hA, 4'h1};
            2'd2:    w_pal = {4'h3, 4'h6, 4'h3};
            default: w_pal = {4'h0, 4'h3, 4'h0};
`else
            2'd0:    w_pal = {4'hF, 4'hF, 4'hF};
            2'd1:    w_pal = {4'hA, 4'hA, 4'hA};
            2'd2:    w_pal = {4'h5, 4'h5, 4'h5};
            default: w_pal = {4'h0, 4'h0, 4'h0};
`endif
        endcase
    end

    // ------------------------------------------------------ output pipeline
    // Stage 1 travels alongside FB_RADDR; stage 2 is the pin register.
    // r_vld1 keeps the pins at their idle values for the first two clocks
    // after reset while the pipeline refills.
    logic    r_vld1;
    logic    r_hs1;
    logic    r_vs1;
    logic    r_win1;
    logic    r_fs1;
    logic    r_hs2;
    logic    r_vs2;
    logic    r_fs2;
    rgb444_t r_rgb2;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_vld1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_win1 <= 1'b0;
            r_fs1  <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_fs2  <= 1'b0;
            r_rgb2 <= '0;
        end else begin
            r_vld1 <= 1'b1;
            r_hs1  <= w_hsync_n;
            r_vs1  <= w_vsync_n;
            r_win1 <= w_in_win;
            r_fs1  <= w_frame_start;
            if (r_vld1) begin
                r_hs2  <= r_hs1;
                r_vs2  <= r_vs1;
                r_fs2  <= r_fs1;
                r_rgb2 <= r_win1 ? w_pal : '0;
            end else begin
                r_hs2  <= 1'b1;
                r_vs2  <= 1'b1;
                r_fs2  <= 1'b0;
                r_rgb2 <= '0;
            end
        end
    end

    assign VGA_HSYNC   = r_hs2;
    assign VGA_VSYNC   = r_vs2;
    assign FRAME_START = r_fs2;
    assign VGA_R       = r_rgb2.r;
    assign VGA_G       = r_rgb2.g;
    assign VGA_B       = r_rgb2.b;

endmodule : gb_vga_scanout
`default_nettype wire

// File: tb/tb_gb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_vga_scanout
// Purpose  : Self-checking bench for gb_vga_scanout. A position model runs
//            alongside the DUT; expected pin values and read addresses are
//            queued per position and compared when the DUT presents them.
//            Memory model: shade = addr[1:0] (mode 0) or constant 2 (mode 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_gb_vga_scanout;
    import gb_vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] fb_raddr;
    logic [1:0]  fb_dout;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    int mode = 0;

    always #20 clk = ~clk;

    // Framebuffer model: data for the address currently presented
    assign fb_dout = (mode == 0) ? fb_raddr[1:0] : 2'd2;

    gb_vga_scanout #(
        .ADDR_WIDTH (15),
        .DATA_WIDTH (2),
        .H_OFFSET   (80),
        .V_OFFSET   (24)
    ) dut (
        .VGA_CLK     (clk),
        .RST         (rst),
        .FB_RADDR    (fb_raddr),
        .FB_DOUT     (fb_dout),
        .VGA_HSYNC   (vga_hsync),
        .VGA_VSYNC   (vga_vsync),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .FRAME_START (frame_start)
    );

    typedef struct {
        logic [14:0] pins;   // {hsync, vsync, frame_start, r, g, b}
        int          h;
        int          v;
    } pexp_t;

    typedef struct {
        bit          chk;
        logic [14:0] addr;
        int          h;
        int          v;
    } aexp_t;

    pexp_t pin_q[$];
    aexp_t addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int mh = 0;
    int mv = 0;
    int cnt_hs;
    int cnt_vs;
    int cnt_fs;

    localparam logic [14:0] c_idle_pins = {1'b1, 1'b1, 1'b0, 12'h000};

    function automatic logic [11:0] pal(input logic [1:0] s);
`ifdef DMG_PALETTE_EN
        case (s)
            2'd0:    return 12'h9B1;
            2'd1:    return 12'h8A1;
            2'd2:    return 12'h363;
            default: return 12'h030;
        endcase
`else
        case (s)
            2'd0:    return 12'hFFF;
            2'd1:    return 12'hAAA;
            2'd2:    return 12'h555;
            default: return 12'h000;
        endcase
`endif
    endfunction

    function automatic bit in_win(input int h, input int v);
        return (h >= 80) && (h <= 559) && (v >= 24) && (v <= 455);
    endfunction

    function automatic logic [14:0] ref_addr(input int h, input int v);
        return 15'(((v - 24) / 3) * 160 + (h - 80) / 3);
    endfunction

    function automatic logic [14:0] ref_pins(input int h, input int v, input int md);
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
        logic [14:0] a;
        logic [1:0]  s;
        hs  = !((h >= 656) && (h <= 751));
        vs  = !((v >= 490) && (v <= 491));
        fs  = (h == 0) && (v == 0);
        a   = ref_addr(h, v);
        s   = (md == 0) ? a[1:0] : 2'd2;
        rgb = in_win(h, v) ? pal(s) : 12'h000;
        return {hs, vs, fs, rgb};
    endfunction

    // One clock: advance the position model, compare whatever the DUT
    // presents now against the queues, then queue expectations for the
    // position now at the counters.
    task automatic cycle();
        bit          was_rst;
        pexp_t       pe;
        aexp_t       ae;
        logic [14:0] obs;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) begin
            mh = 0;
            mv = 0;
            pin_q.delete();
            addr_q.delete();
            pin_q.push_back('{pins: c_idle_pins, h: -1, v: -1});
            pin_q.push_back('{pins: c_idle_pins, h: -1, v: -1});
            addr_q.push_back('{chk: 1'b1, addr: 15'd0, h: -1, v: -1});
        end else begin
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0;
                mv++;
                if (mv == V_TOTAL) mv = 0;
            end
        end

        pe  = pin_q.pop_front();
        obs = {vga_hsync, vga_vsync, frame_start, vga_r, vga_g, vga_b};
        n_tests++;
        assert (obs === pe.pins) else begin
            n_fail++;
            $error("FAIL pins h=%0d v=%0d: got %h want %h", pe.h, pe.v, obs, pe.pins);
        end

        ae = addr_q.pop_front();
        if (ae.chk) begin
            n_tests++;
            assert (fb_raddr === ae.addr) else begin
                n_fail++;
                $error("FAIL raddr h=%0d v=%0d: got %0d want %0d", ae.h, ae.v, fb_raddr, ae.addr);
            end
        end

        pin_q.push_back('{pins: ref_pins(mh, mv, mode), h: mh, v: mv});
        addr_q.push_back('{chk: in_win(mh, mv), addr: ref_addr(mh, mv), h: mh, v: mv});
    endtask

    initial begin
        // Reset held for two clocks
        rst  = 1'b1;
        mode = 0;
        cycle();
        cycle();
        rst = 1'b0;

        // Frame 1, address-derived shades: every pixel, sync and window
        // address is checked, and sync activity is totalled over one frame.
        cnt_hs = 0;
        cnt_vs = 0;
        cnt_fs = 0;
        for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
            cycle();
            if (!vga_hsync) cnt_hs++;
            if (!vga_vsync) cnt_vs++;
            if (frame_start) cnt_fs++;
        end
        n_tests++;
        assert (cnt_hs === 96 * 525) else begin
            n_fail++;
            $error("FAIL hsync_low_count: got %0d want %0d", cnt_hs, 96 * 525);
        end
        n_tests++;
        assert (cnt_vs === 1600) else begin
            n_fail++;
            $error("FAIL vsync_low_count: got %0d want %0d", cnt_vs, 1600);
        end
        n_tests++;
        assert (cnt_fs === 1) else begin
            n_fail++;
            $error("FAIL frame_start_count: got %0d want %0d", cnt_fs, 1);
        end

        // Frame 2 starts with no window pixel in flight: switch to constant
        // shade 2 and run through the wrap up to (300,200).
        mode = 1;
        for (int i = 0; i < 200 * H_TOTAL + 300; i++) cycle();

        // Mid-frame reset for one clock at (300,200)
        rst  = 1'b1;
        mode = 0;
        cycle();
        rst = 1'b0;

        // Restart from (0,0) and re-enter the window
        for (int i = 0; i < 25 * H_TOTAL + 100; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gb_vga_scanout
`default_nettype wire
